beam_steer_scheduler: RTL and testbench

//  Sequences the per-channel delay read indices of the dual I2S delay buffers so the summed output steers between

---
 rtl/beam_steer_scheduler_pkg.sv | 18 +
 rtl/beam_delay_table.sv | 51 +++++
 rtl/beam_steer_scheduler.sv | 137 +++++++++++++
 tb/tb_beam_steer_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_steer_scheduler_pkg.sv
// Shared constants, FSM state type and width helper for the beam steering scheduler.
// Delay-index width is derived from the delay buffer depth rather than fixed.
package beam_steer_scheduler_pkg;

    localparam int unsigned BUFFER_SIZE = 8;
    localparam int unsigned INDEX_WIDTH = $clog2(BUFFER_SIZE);

    typedef enum logic [0:0] {
        StIdle,
        StSweep
    } sched_state_e;

    // Width of an index for n items, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/beam_delay_table.sv
// Double-buffered delay-index table: shadow written by commits, active copied in bulk on apply,
// active read out for the selected beam.
module beam_delay_table
    import beam_steer_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned NUM_BEAMS    = 4,
    localparam int unsigned ChW         = clog2_min1(NUM_CHANNELS),
    localparam int unsigned BeamW       = clog2_min1(NUM_BEAMS)
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                commit_i,
    input  logic [BeamW-1:0]                    commit_beam_i,
    input  logic [ChW-1:0]                      commit_sel_i,
    input  logic [INDEX_WIDTH-1:0]              commit_data_i,
    input  logic                                apply_i,
    input  logic [BeamW-1:0]                    rd_beam_i,
    output logic [NUM_CHANNELS*INDEX_WIDTH-1:0] rd_data_o
);

    logic [INDEX_WIDTH-1:0] shadow_q [NUM_BEAMS][NUM_CHANNELS];
    logic [INDEX_WIDTH-1:0] active_q [NUM_BEAMS][NUM_CHANNELS];

    // Apply copies the shadow as it stood before any same-cycle commit
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int b = 0; b < int'(NUM_BEAMS); b++) begin
                for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                    shadow_q[b][c] <= '0;
                    active_q[b][c] <= '0;
                end
            end
        end else begin
            if (apply_i) begin
                active_q <= shadow_q;
            end
            if (commit_i) begin
                shadow_q[commit_beam_i][commit_sel_i] <= commit_data_i;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
            rd_data_o[c*INDEX_WIDTH +: INDEX_WIDTH] = active_q[rd_beam_i][c];
        end
    end

endmodule

// File: rtl/beam_steer_scheduler.sv
// Frame-synchronous beam scheduler: serial config into a shadow table, frame-edge apply,
// manual/sweep beam selection and registered per-channel delay indices.
module beam_steer_scheduler
    import beam_steer_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned NUM_BEAMS    = 4,
    parameter int unsigned DWELL_FRAMES = 8,
    localparam int unsigned ChW         = clog2_min1(NUM_CHANNELS),
    localparam int unsigned SelW        = ChW + 1,
    localparam int unsigned BeamW       = clog2_min1(NUM_BEAMS),
    localparam int unsigned DwellW      = clog2_min1(DWELL_FRAMES)
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                ws_i,
    input  logic                                cfg_data_i,
    input  logic                                cfg_we_i,
    // One spare bit so an out-of-range channel select can be expressed and flagged
    input  logic [SelW-1:0]                     cfg_sel_i,
    input  logic [BeamW-1:0]                    cfg_beam_i,
    input  logic                                cfg_commit_i,
    input  logic                                sweep_en_i,
    input  logic [BeamW-1:0]                    manual_beam_i,
    output logic [NUM_CHANNELS*INDEX_WIDTH-1:0] delay_index_o,
    output logic [BeamW-1:0]                    beam_id_o,
    output logic                                frame_tick_o,
    output logic                                cfg_pending_o,
    output logic                                cfg_err_o
);

    sched_state_e                        state_q, state_d;
    logic                                ws_q;
    logic                                frame_tick_q, frame_tick_d;
    logic [INDEX_WIDTH-1:0]              sh_q, sh_d;
    logic [BeamW-1:0]                    beam_id_q, beam_id_d;
    logic [DwellW-1:0]                   dwell_q, dwell_d;
    logic                                pending_q, pending_d;
    logic                                err_q, err_d;
    logic [NUM_CHANNELS*INDEX_WIDTH-1:0] delay_index_q;
    logic [NUM_CHANNELS*INDEX_WIDTH-1:0] table_rd;
    logic                                sel_ok, commit_ok, apply;

    assign sel_ok    = cfg_sel_i < SelW'(NUM_CHANNELS);
    assign commit_ok = cfg_commit_i & sel_ok;
    assign apply     = frame_tick_q & pending_q;

    always_comb begin
        frame_tick_d = ws_q & ~ws_i;
        sh_d         = cfg_we_i ? {sh_q[INDEX_WIDTH-2:0], cfg_data_i} : sh_q;
        err_d        = err_q | (cfg_commit_i & ~sel_ok);
        pending_d    = pending_q;
        if (apply) begin
            pending_d = 1'b0;
        end
        if (commit_ok) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        beam_id_d = beam_id_q;
        dwell_d   = dwell_q;
        if (frame_tick_q) begin
            unique case (state_q)
                StIdle: begin
                    if (sweep_en_i) begin
                        state_d = StSweep;
                        dwell_d = '0;
                    end else begin
                        beam_id_d = manual_beam_i;
                    end
                end
                StSweep: begin
                    if (!sweep_en_i) begin
                        state_d   = StIdle;
                        beam_id_d = manual_beam_i;
                    end else if (dwell_q == DwellW'(DWELL_FRAMES - 1)) begin
                        dwell_d   = '0;
                        beam_id_d = beam_id_q + BeamW'(1);
                    end else begin
                        dwell_d = dwell_q + DwellW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            ws_q          <= 1'b0;
            frame_tick_q  <= 1'b0;
            sh_q          <= '0;
            beam_id_q     <= '0;
            dwell_q       <= '0;
            pending_q     <= 1'b0;
            err_q         <= 1'b0;
            delay_index_q <= '0;
        end else begin
            state_q       <= state_d;
            ws_q          <= ws_i;
            frame_tick_q  <= frame_tick_d;
            sh_q          <= sh_d;
            beam_id_q     <= beam_id_d;
            dwell_q       <= dwell_d;
            pending_q     <= pending_d;
            err_q         <= err_d;
            // Table and beam only move on a tick, so this follows one clk behind them
            delay_index_q <= table_rd;
        end
    end

    beam_delay_table #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .NUM_BEAMS    (NUM_BEAMS)
    ) u_table (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .commit_i      (commit_ok),
        .commit_beam_i (cfg_beam_i),
        .commit_sel_i  (cfg_sel_i[ChW-1:0]),
        .commit_data_i (sh_q),
        .apply_i       (apply),
        .rd_beam_i     (beam_id_q),
        .rd_data_o     (table_rd)
    );

    assign delay_index_o = delay_index_q;
    assign beam_id_o     = beam_id_q;
    assign frame_tick_o  = frame_tick_q;
    assign cfg_pending_o = pending_q;
    assign cfg_err_o     = err_q;

endmodule

// File: tb/tb_beam_steer_scheduler.sv
// Directed and randomized bench for beam_steer_scheduler against a frame-level reference model.
module tb_beam_steer_scheduler;

    localparam int NC    = 2;
    localparam int NB    = 4;
    localparam int DW    = 2;
    localparam int IW    = 3;
    localparam int IMASK = (1 << IW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ws;
    logic          cfg_data;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [1:0]    cfg_beam;
    logic          cfg_commit;
    logic          sweep_en;
    logic [1:0]    manual_beam;
    logic [NC*IW-1:0] delay_index;
    logic [1:0]    beam_id;
    logic          frame_tick;
    logic          cfg_pending;
    logic          cfg_err;

    int checks = 0;
    int errors = 0;

    // Reference model state, updated per operation / per frame
    int m_shadow [NB][NC];
    int m_active [NB][NC];
    int m_sh;
    bit m_pend;
    bit m_err;
    int m_beam;
    bit m_sweeping;
    int m_base;
    int m_ticks;

    always #5 clk = ~clk;

    beam_steer_scheduler #(
        .NUM_CHANNELS (NC),
        .NUM_BEAMS    (NB),
        .DWELL_FRAMES (DW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .ws_i          (ws),
        .cfg_data_i    (cfg_data),
        .cfg_we_i      (cfg_we),
        .cfg_sel_i     (cfg_sel),
        .cfg_beam_i    (cfg_beam),
        .cfg_commit_i  (cfg_commit),
        .sweep_en_i    (sweep_en),
        .manual_beam_i (manual_beam),
        .delay_index_o (delay_index),
        .beam_id_o     (beam_id),
        .frame_tick_o  (frame_tick),
        .cfg_pending_o (cfg_pending),
        .cfg_err_o     (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC*IW-1:0] exp_idx();
        logic [NC*IW-1:0] v;
        for (int c = 0; c < NC; c++) v[c*IW +: IW] = IW'(m_active[m_beam][c]);
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < NC; c++) begin
                m_shadow[b][c] = 0;
                m_active[b][c] = 0;
            end
        m_sh = 0; m_pend = 0; m_err = 0; m_beam = 0;
        m_sweeping = 0; m_base = 0; m_ticks = 0;
    endtask

    // Frame-level view: beam in a sweep is base + (frames since entry / dwell)
    task automatic model_tick();
        if (m_pend) begin
            m_active = m_shadow;
            m_pend = 0;
        end
        if (!m_sweeping) begin
            if (sweep_en) begin
                m_sweeping = 1; m_base = m_beam; m_ticks = 0;
            end else begin
                m_beam = int'(manual_beam);
            end
        end else if (!sweep_en) begin
            m_sweeping = 0;
            m_beam = int'(manual_beam);
        end else begin
            m_ticks++;
            m_beam = (m_base + m_ticks / DW) % NB;
        end
    endtask

    task automatic model_commit(input int b, input int s);
        if (s < NC) begin
            m_shadow[b][s] = m_sh;
            m_pend = 1;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic shift_bits(input int n, input int val);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_data = val[i];
            cfg_we = 1'b1;
            @(negedge clk);
            m_sh = ((m_sh << 1) | val[i]) & IMASK;
        end
        cfg_we = 1'b0;
    endtask

    task automatic commit(input int b, input int s);
        cfg_beam = 2'(b);
        cfg_sel = 2'(s);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        model_commit(b, s);
        chk("commit_pending", cfg_pending, m_pend);
        chk("commit_err", cfg_err, m_err);
    endtask

    task automatic load(input int b, input int s, input int val);
        shift_bits(IW, val);
        commit(b, s);
    endtask

    // One ws falling edge; optionally commit in the cycle frame_tick is high
    task automatic frame(input bit commit_at_tick, input int cb, input int cs);
        logic [NC*IW-1:0] old;
        old = exp_idx();
        chk("pending_pre", cfg_pending, m_pend);
        ws = 1'b0;
        @(negedge clk);
        chk("tick_high", frame_tick, 1);
        chk("idx_hold1", delay_index, old);
        if (commit_at_tick) begin
            cfg_beam = 2'(cb);
            cfg_sel = 2'(cs);
            cfg_commit = 1'b1;
        end
        @(negedge clk);
        cfg_commit = 1'b0;
        model_tick();
        if (commit_at_tick) model_commit(cb, cs);
        chk("tick_low", frame_tick, 0);
        chk("beam_id", beam_id, m_beam);
        chk("pending_post", cfg_pending, m_pend);
        chk("err", cfg_err, m_err);
        chk("idx_hold2", delay_index, old);
        @(negedge clk);
        chk("idx_new", delay_index, exp_idx());
        repeat (12) @(negedge clk);
        chk("idx_stable", delay_index, exp_idx());
        ws = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    int exp_seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        reset = 1'b1; ws = 1'b1; cfg_data = 1'b0; cfg_we = 1'b0; cfg_sel = '0;
        cfg_beam = '0; cfg_commit = 1'b0; sweep_en = 1'b0; manual_beam = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: reset state, ws toggling leaves outputs at zero
        chk("rst_idx", delay_index, 0);
        chk("rst_beam", beam_id, 0);
        chk("rst_pending", cfg_pending, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_tick", frame_tick, 0);
        frame(0, 0, 0);
        frame(0, 0, 0);

        // 2: single commit applied only at the frame edge
        load(0, 1, 3'b101);
        chk("t2_idx_before", delay_index, 0);
        frame(0, 0, 0);
        chk("t2_ch1", delay_index[5:3], 5);

        // 3: sweep through beams with dwell of two frames
        for (int b = 0; b < NB; b++) load(b, 0, b + 1);
        sweep_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            frame(0, 0, 0);
            chk("t3_seq", beam_id, exp_seq[i]);
            chk("t3_ch0", delay_index[2:0], exp_seq[i] + 1);
        end

        // 4: commit coinciding with frame_tick lands one frame later
        sweep_en = 1'b0;
        manual_beam = 2'd2;
        shift_bits(IW, 6);
        frame(1, 2, 0);
        chk("t4_pending_held", cfg_pending, 1);
        chk("t4_not_applied", delay_index[2:0], 3);
        frame(0, 0, 0);
        chk("t4_applied", delay_index[2:0], 6);

        // 5: out-of-range channel select is flagged and writes nothing
        shift_bits(IW, 7);
        commit(2, 2);
        chk("t5_no_pending", cfg_pending, 0);
        frame(0, 0, 0);
        chk("t5_idx", delay_index[2:0], 6);
        chk("t5_err_sticky", cfg_err, 1);

        // 6: reset mid-sweep with a pending commit and a half-shifted word
        sweep_en = 1'b1;
        frame(0, 0, 0);
        frame(0, 0, 0);
        load(1, 1, 4);
        shift_bits(2, 3);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        chk("t6_idx", delay_index, 0);
        chk("t6_beam", beam_id, 0);
        chk("t6_pending", cfg_pending, 0);
        chk("t6_err", cfg_err, 0);
        chk("t6_tick", frame_tick, 0);
        reset = 1'b0;
        sweep_en = 1'b0;
        manual_beam = 2'd2;
        repeat (2) @(negedge clk);
        frame(0, 0, 0);
        chk("t6_manual", beam_id, 2);

        // Randomized frames against the model
        for (int f = 0; f < 60; f++) begin
            int nops;
            nops = $urandom_range(0, 3);
            for (int k = 0; k < nops; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    shift_bits($urandom_range(1, 5), $urandom_range(0, 31));
                end else begin
                    commit($urandom_range(0, NB - 1),
                           ($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, NC - 1));
                end
            end
            if ($urandom_range(0, 3) == 0) sweep_en = ~sweep_en;
            manual_beam = 2'($urandom_range(0, NB - 1));
            if ($urandom_range(0, 5) == 0)
                frame(1, $urandom_range(0, NB - 1), $urandom_range(0, NC - 1));
            else
                frame(0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
